// File: rtl/armleo_mem_1wnr.sv
// armleo_mem_1wnr: one write port, N independent registered read ports.
// On reset and on request the array is swept to zero one word per cycle,
// and busy stays high for the whole sweep. Byte-lane write enables are
// supported. A read that hits the word being written returns either the
// merged new word (write-first) or the old word (read-first).
// Handshake: none. read[p] is a single-cycle request that is always
// accepted outside the sweep; rvalid[p] marks the cycle rdata for port p
// was refreshed. There is no ready and no stall.
module armleo_mem_1wnr #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIDTH      = 32,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  output logic                             busy,
  input  logic                             write,
  input  logic [DEPTH_LOG2-1:0]            waddr,
  input  logic [WIDTH-1:0]                 wdata,
  input  logic [WIDTH/8-1:0]               wbyte_en,
  input  logic [READ_PORTS-1:0]            read,
  input  logic [READ_PORTS*DEPTH_LOG2-1:0] raddr,
  output logic [READ_PORTS*WIDTH-1:0]      rdata,
  output logic [READ_PORTS-1:0]            rvalid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BYTES = WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   sweep_addr;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [BYTES-1:0]        mem_be;
  logic [WIDTH-1:0]        rd_word [READ_PORTS];

  // busy is a direct view of the FSM state and doubles as its debug output.
  assign busy = (state == ST_CLEAR);

  // Sweep FSM: CLEAR walks every address once, IDLE waits for a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Counter wraps back to zero on the last address, ready for the next sweep.
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == {DEPTH_LOG2{1'b1}}) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clear) state <= ST_CLEAR;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Single array write port: the sweep owns it in CLEAR, the user in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    mem_be    = wbyte_en;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
      mem_wdata = '0;
      mem_be    = '1;
    end else begin
      mem_we    = write;
    end
  end

  // Array storage is never reset; the sweep is what establishes zeros.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Per-port read word, with write-first lane merge on an address hit.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_word[p] = mem[raddr[p*DEPTH_LOG2 +: DEPTH_LOG2]];
      if ((BYPASS != 0) && write && (raddr[p*DEPTH_LOG2 +: DEPTH_LOG2] == waddr)) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wbyte_en[b]) rd_word[p][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read outputs; data holds whenever no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if ((state == ST_IDLE) && read[p]) begin
          rdata[p*WIDTH +: WIDTH] <= rd_word[p];
          rvalid[p]               <= 1'b1;
        end else begin
          rvalid[p]               <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_armleo_mem_1wnr.sv
// Bench for armleo_mem_1wnr: a write-first and a read-first instance share
// all inputs and are checked every cycle against an array-level model,
// with directed literal checks anchoring the model.
module tb_armleo_mem_1wnr;

  localparam int DL = 4;
  localparam int W  = 32;
  localparam int RP = 2;
  localparam int N  = 1 << DL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            clear;
  logic            write;
  logic [DL-1:0]   waddr;
  logic [W-1:0]    wdata;
  logic [W/8-1:0]  wbyte_en;
  logic [RP-1:0]   read;
  logic [RP*DL-1:0] raddr;

  logic            busy_wf, busy_rf;
  logic [RP*W-1:0] rdata_wf, rdata_rf;
  logic [RP-1:0]   rvalid_wf, rvalid_rf;

  armleo_mem_1wnr #(.DEPTH_LOG2(DL), .WIDTH(W), .READ_PORTS(RP), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_wf),
    .write(write), .waddr(waddr), .wdata(wdata), .wbyte_en(wbyte_en),
    .read(read), .raddr(raddr), .rdata(rdata_wf), .rvalid(rvalid_wf)
  );

  armleo_mem_1wnr #(.DEPTH_LOG2(DL), .WIDTH(W), .READ_PORTS(RP), .BYPASS(0)) dut_rf (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_rf),
    .write(write), .waddr(waddr), .wdata(wdata), .wbyte_en(wbyte_en),
    .read(read), .raddr(raddr), .rdata(rdata_rf), .rvalid(rvalid_rf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory as a plain array; the sweep is a count of remaining zero-fill cycles.
  logic [W-1:0] m_mem [N];
  int           sweep_left;
  logic [W-1:0] exp_wf [RP];
  logic [W-1:0] exp_rf [RP];
  logic [RP-1:0] exp_rv;

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_left = N;
      exp_rv     = '0;
      for (int p = 0; p < RP; p++) begin
        exp_wf[p] = '0;
        exp_rf[p] = '0;
      end
    end else if (sweep_left > 0) begin
      m_mem[N - sweep_left] = '0;
      sweep_left--;
      exp_rv = '0;
    end else begin
      logic [W-1:0] merged;
      merged = m_mem[waddr];
      for (int b = 0; b < W/8; b++)
        if (wbyte_en[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
      for (int p = 0; p < RP; p++) begin
        int ra;
        ra = int'(raddr[p*DL +: DL]);
        if (read[p]) begin
          exp_rf[p] = m_mem[ra];
          exp_wf[p] = (write && ra == int'(waddr)) ? merged : m_mem[ra];
          exp_rv[p] = 1'b1;
        end else begin
          exp_rv[p] = 1'b0;
        end
      end
      if (write) m_mem[waddr] = merged;
      if (clear) sweep_left = N;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    check("busy_wf", {31'd0, busy_wf}, {31'd0, sweep_left > 0});
    check("busy_rf", {31'd0, busy_rf}, {31'd0, sweep_left > 0});
    check("rvalid_wf", {30'd0, rvalid_wf}, {30'd0, exp_rv});
    check("rvalid_rf", {30'd0, rvalid_rf}, {30'd0, exp_rv});
    for (int p = 0; p < RP; p++) begin
      check($sformatf("rdata_wf[%0d]", p), rdata_wf[p*W +: W], exp_wf[p]);
      check($sformatf("rdata_rf[%0d]", p), rdata_rf[p*W +: W], exp_rf[p]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    clear = 1'b0; write = 1'b0; waddr = '0; wdata = '0; wbyte_en = '0;
    read = '0; raddr = '0;
  endtask

  // One cycle: drive at negedge, the next posedge consumes, return at next negedge.
  task automatic cycle_write(input int a, input logic [W-1:0] d, input logic [3:0] be);
    @(negedge clk);
    idle_inputs();
    write = 1'b1; waddr = DL'(a); wdata = d; wbyte_en = be;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic cycle_read(input int a0, input int a1);
    @(negedge clk);
    idle_inputs();
    read = 2'b11; raddr = {DL'(a1), DL'(a0)};
    @(negedge clk);
    idle_inputs();
  endtask

  // Counts cycles busy stays high, starting from a point where it is already high.
  task automatic measure_busy(output int n, input bit repulse);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (repulse && n == 5) clear = 1'b1;
      if (n == 6) clear = 1'b0;
      if (n == 8) check("rvalid_during_sweep", {30'd0, rvalid_wf}, 32'd0);
    end while (busy_wf && n < 100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy_wf}, 32'd1);
    check("reset_rvalid", {30'd0, rvalid_wf}, 32'd0);
    check("reset_rdata0", rdata_wf[W-1:0], 32'd0);

    // Release and time the power-on sweep.
    rst_n = 1'b1;
    measure_busy(n, 1'b0);
    check("por_busy_len", n, 32'd16);

    // Every address reads zero on both ports.
    for (int a = 0; a < N; a++) begin
      cycle_read(a, N - 1 - a);
      check("zero_p0", rdata_wf[W-1:0], 32'd0);
      check("zero_p1", rdata_wf[2*W-1:W], 32'd0);
      check("zero_rvalid", {30'd0, rvalid_wf}, 32'd3);
    end

    // Full-word writes, then a parallel read.
    cycle_write(5, 32'd100, 4'hF);
    cycle_write(6, 32'd101, 4'hF);
    cycle_read(5, 6);
    check("wr5_p0", rdata_wf[W-1:0], 32'd100);
    check("wr6_p1", rdata_wf[2*W-1:W], 32'd101);

    // Same address on both ports.
    cycle_read(6, 6);
    check("same_addr", rdata_wf[W-1:0], rdata_wf[2*W-1:W]);

    // Byte-lane collision: write-first merges, read-first returns old word.
    cycle_write(3, 32'h11223344, 4'hF);
    @(negedge clk);
    idle_inputs();
    write = 1'b1; waddr = 4'd3; wdata = 32'hAABBCCDD; wbyte_en = 4'b0101;
    read = 2'b01; raddr = {4'd0, 4'd3};
    @(negedge clk);
    idle_inputs();
    check("collide_wf", rdata_wf[W-1:0], 32'h11BB33DD);
    check("collide_rf", rdata_rf[W-1:0], 32'h11223344);
    cycle_read(3, 3);
    check("after_wf", rdata_wf[W-1:0], 32'h11BB33DD);
    check("after_rf", rdata_rf[W-1:0], 32'h11BB33DD);

    // Clear with a mid-sweep re-pulse; reads during the sweep are dropped.
    cycle_write(7, 32'hDEADBEEF, 4'hF);
    cycle_read(7, 7);
    check("mem7_set", rdata_wf[W-1:0], 32'hDEADBEEF);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    read = 2'b11; raddr = {4'd7, 4'd7};
    check("clear_busy", {31'd0, busy_wf}, 32'd1);
    measure_busy(n, 1'b1);
    check("clear_busy_len", n, 32'd16);
    check("rdata_held", rdata_wf[W-1:0], 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    cycle_read(7, 5);
    check("mem7_cleared", rdata_wf[W-1:0], 32'd0);
    check("mem5_cleared", rdata_wf[2*W-1:W], 32'd0);

    // Reset mid-sweep at address 9, then a full 16-cycle sweep after release.
    cycle_write(2, 32'hCAFEF00D, 4'hF);
    cycle_read(2, 2);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy_wf}, 32'd1);
    check("rst_rdata", rdata_wf[W-1:0], 32'd0);
    check("rst_rvalid", {30'd0, rvalid_wf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure_busy(n, 1'b0);
    check("rst_busy_len", n, 32'd16);

    // Random traffic checked by the scoreboard, with frequent collisions.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      write    = 1'($urandom_range(0, 1));
      waddr    = DL'($urandom_range(0, N - 1));
      wdata    = $urandom;
      wbyte_en = 4'($urandom_range(0, 15));
      read     = 2'($urandom_range(0, 3));
      for (int p = 0; p < RP; p++)
        raddr[p*DL +: DL] = ($urandom_range(0, 2) == 0) ? waddr : DL'($urandom_range(0, N - 1));
      clear    = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    idle_inputs();
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
